// File: rtl/data_ram_responder_pkg.sv
// Shared constants, response record and address helpers for the data-RAM responder.
//   ADDR_BUS / DATA_BUS : request address and data widths.
//   ZERO_64             : all-zero doubleword.
//   RAM_BASE_ADDR       : default byte address of doubleword 0.
//   rd_resp_t           : {valid, err, data} carried through the read pipeline.
package data_ram_responder_pkg;

    localparam int unsigned ADDR_BUS = 64;
    localparam int unsigned DATA_BUS = 64;

    localparam logic [DATA_BUS-1:0] ZERO_64       = '0;
    localparam logic [ADDR_BUS-1:0] RAM_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic                valid;
        logic                err;
        logic [DATA_BUS-1:0] data;
    } rd_resp_t;

    localparam int unsigned RD_RESP_W = $bits(rd_resp_t);

    // Addresses below base wrap to huge offsets under unsigned subtraction, so the
    // explicit addr >= base term is what rejects them.
    function automatic logic addr_in_range(input logic [ADDR_BUS-1:0] addr,
                                           input logic [ADDR_BUS-1:0] base,
                                           input int unsigned         depth);
        logic [ADDR_BUS-1:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 3) < ADDR_BUS'(depth));
    endfunction

    function automatic logic [DATA_BUS-1:0] masked_merge(input logic [DATA_BUS-1:0] old_data,
                                                         input logic [DATA_BUS-1:0] new_data,
                                                         input logic [DATA_BUS-1:0] mask);
        return (old_data & ~mask) | (new_data & mask);
    endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// Data-RAM request/response bundle between the memory stage and the RAM.
//   master : requester side (drives read/write requests, receives read data).
//   slave  : RAM side (receives requests, returns data, valid and error flags).
interface data_ram_responder_if;
    import data_ram_responder_pkg::*;

    logic                RamReadEnable;
    logic [ADDR_BUS-1:0] RamReadAddr;
    logic                RamWriteEnable;
    logic [ADDR_BUS-1:0] RamWriteAddr;
    logic [DATA_BUS-1:0] RamWriteData;
    logic [DATA_BUS-1:0] RamWriteMask;
    logic [DATA_BUS-1:0] RamReadData;
    logic                RamReadValid;
    logic                RamReadErr;
    logic                RamWriteErr;

    modport master (
        output RamReadEnable, RamReadAddr,
        output RamWriteEnable, RamWriteAddr, RamWriteData, RamWriteMask,
        input  RamReadData, RamReadValid, RamReadErr, RamWriteErr
    );

    modport slave (
        input  RamReadEnable, RamReadAddr,
        input  RamWriteEnable, RamWriteAddr, RamWriteData, RamWriteMask,
        output RamReadData, RamReadValid, RamReadErr, RamWriteErr
    );

endinterface

// File: rtl/data_ram_responder_rd_pipe.sv
// ram_rd_pipe: N-stage register chain for the packed read response.
//   clk, rst : clock, synchronous active-high reset (clears every stage).
//   resp_i   : response formed at request time.
//   resp_o   : response delayed by N cycles; N = 0 is a plain wire.
module ram_rd_pipe #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] resp_i,
    output logic [W-1:0] resp_o
);

    if (N == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign resp_o         = resp_i;
    end else begin : g_stages
        logic [W-1:0] stage_q [N];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < N; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= resp_i;
                for (int unsigned i = 1; i < N; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign resp_o = stage_q[N-1];
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data-RAM responder: register-array backing store for the core's data side.
//   clk, rst : clock, synchronous active-high reset (pipeline and error flag only;
//              array contents survive reset, writes are blocked while rst=1).
//   bus      : slave side of data_ram_responder_if (read/write requests in,
//              read data/valid/err and write error out).
// Parameters: DEPTH doublewords (power of two), READ_LAT 0..3 cycles,
//             BASE_ADDR byte address of doubleword 0.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int unsigned         DEPTH     = 4096,
    parameter int unsigned         READ_LAT  = 0,
    parameter logic [ADDR_BUS-1:0] BASE_ADDR = RAM_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_BUS-1:0] mem [DEPTH];

    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_hit;
    logic             wr_err_q;

    rd_resp_t rd_req;
    rd_resp_t rd_resp;
    rd_resp_t rd_out;

    // Address decode; the index is only meaningful when the matching *_ok is set.
    always_comb begin
        rd_ok  = addr_in_range(bus.RamReadAddr, BASE_ADDR, DEPTH);
        rd_idx = IDX_W'((bus.RamReadAddr - BASE_ADDR) >> 3);
        wr_ok  = addr_in_range(bus.RamWriteAddr, BASE_ADDR, DEPTH);
        wr_idx = IDX_W'((bus.RamWriteAddr - BASE_ADDR) >> 3);
        wr_hit = bus.RamWriteEnable && wr_ok && !rst;
    end

    // Array update lands on the edge, so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[wr_idx] <= masked_merge(mem[wr_idx], bus.RamWriteData, bus.RamWriteMask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.RamWriteEnable && !wr_ok;
        end
    end

    // Data is captured here at issue time; later writes cannot reach in-flight reads.
    always_comb begin
        rd_req       = '0;
        rd_req.valid = bus.RamReadEnable;
        rd_req.err   = bus.RamReadEnable && !rd_ok;
        rd_req.data  = ZERO_64;
        if (bus.RamReadEnable && rd_ok) begin
            rd_req.data = mem[rd_idx];
        end
    end

    ram_rd_pipe #(
        .W (RD_RESP_W),
        .N (READ_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .resp_i (rd_req),
        .resp_o (rd_resp)
    );

    // With no pipeline there is no register to clear, so reset masks the outputs.
    always_comb begin
        rd_out = rd_resp;
        if ((READ_LAT == 0) && rst) begin
            rd_out = '0;
        end
    end

    assign bus.RamReadData  = rd_out.data;
    assign bus.RamReadValid = rd_out.valid;
    assign bus.RamReadErr   = rd_out.err;
    assign bus.RamWriteErr  = wr_err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: three instances (READ_LAT 0, 2, 3) on a shared
// clock/reset. Latency 0 is driven from a vector table; latencies 2 and 3 use a
// shadow memory and per-instance expected-response queues.
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam logic [63:0] B     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] F     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_ram_responder_if if0 ();
    data_ram_responder_if if2 ();
    data_ram_responder_if if3 ();

    data_ram_responder #(.DEPTH(DEPTH), .READ_LAT(0), .BASE_ADDR(B)) u_lat0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    data_ram_responder #(.DEPTH(DEPTH), .READ_LAT(2), .BASE_ADDR(B)) u_lat2 (
        .clk (clk), .rst (rst), .bus (if2)
    );
    data_ram_responder #(.DEPTH(DEPTH), .READ_LAT(3), .BASE_ADDR(B)) u_lat3 (
        .clk (clk), .rst (rst), .bus (if3)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q2[$];
    exp_t        q3[$];
    logic [63:0] m2 [DEPTH];
    logic [63:0] m3 [DEPTH];

    typedef struct {
        logic        re;
        logic [63:0] ra;
        logic        we;
        logic [63:0] wa;
        logic [63:0] wd;
        logic [63:0] wm;
        logic [63:0] ed;
        logic        ev;
        logic        ee;
        logic        ew;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic in_rng(input logic [63:0] a);
        return (a >= B) && (a < B + 64'(DEPTH * 8));
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        logic [63:0] off;
        off = a - B;
        return int'(off[6:3]);
    endfunction

    task automatic clear_all();
        if0.RamReadEnable = 1'b0; if0.RamReadAddr = '0; if0.RamWriteEnable = 1'b0;
        if0.RamWriteAddr = '0; if0.RamWriteData = '0; if0.RamWriteMask = '0;
        if2.RamReadEnable = 1'b0; if2.RamReadAddr = '0; if2.RamWriteEnable = 1'b0;
        if2.RamWriteAddr = '0; if2.RamWriteData = '0; if2.RamWriteMask = '0;
        if3.RamReadEnable = 1'b0; if3.RamReadAddr = '0; if3.RamWriteEnable = 1'b0;
        if3.RamWriteAddr = '0; if3.RamWriteData = '0; if3.RamWriteMask = '0;
    endtask

    task automatic monitor();
        exp_t e;
        if (if2.RamReadValid === 1'b1) begin
            if (q2.size() == 0) begin
                chk("lat2_stray_valid", 64'(if2.RamReadValid), 64'd0);
            end else begin
                e = q2.pop_front();
                chk("lat2_data", if2.RamReadData, e.data);
                chk("lat2_err", 64'(if2.RamReadErr), 64'(e.err));
                chk("lat2_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q2.size() != 0 && q2[0].due <= cyc) begin
            chk("lat2_missing_valid", 64'(if2.RamReadValid), 64'd1);
            void'(q2.pop_front());
        end
        if (if3.RamReadValid === 1'b1) begin
            if (q3.size() == 0) begin
                chk("lat3_stray_valid", 64'(if3.RamReadValid), 64'd0);
            end else begin
                e = q3.pop_front();
                chk("lat3_data", if3.RamReadData, e.data);
                chk("lat3_err", 64'(if3.RamReadErr), 64'(e.err));
                chk("lat3_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q3.size() != 0 && q3[0].due <= cyc) begin
            chk("lat3_missing_valid", 64'(if3.RamReadValid), 64'd1);
            void'(q3.pop_front());
        end
    endtask

    task automatic half();
        @(negedge clk);
        monitor();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        clear_all();
    endtask

    task automatic cyc_end();
        half();
        step();
    endtask

    // Drive one cycle on a pipelined instance and update its shadow model.
    task automatic drv(input int lat, input logic re, input logic [63:0] ra, input logic we,
                       input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] wm);
        exp_t e;
        if (lat == 2) begin
            if2.RamReadEnable = re; if2.RamReadAddr = ra; if2.RamWriteEnable = we;
            if2.RamWriteAddr = wa; if2.RamWriteData = wd; if2.RamWriteMask = wm;
        end else begin
            if3.RamReadEnable = re; if3.RamReadAddr = ra; if3.RamWriteEnable = we;
            if3.RamWriteAddr = wa; if3.RamWriteData = wd; if3.RamWriteMask = wm;
        end
        if (re) begin
            e.err  = !in_rng(ra);
            e.data = e.err ? 64'd0 : ((lat == 2) ? m2[idx_of(ra)] : m3[idx_of(ra)]);
            e.due  = cyc + lat;
            if (lat == 2) q2.push_back(e);
            else          q3.push_back(e);
        end
        if (we && in_rng(wa)) begin
            if (lat == 2) m2[idx_of(wa)] = (m2[idx_of(wa)] & ~wm) | (wd & wm);
            else          m3[idx_of(wa)] = (m3[idx_of(wa)] & ~wm) | (wd & wm);
        end
        cyc_end();
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (q2.size() != 0 || q3.size() != 0); i++) begin
            cyc_end();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //            re  ra              we  wa              wd                     wm                     ed                     ev  ee  ew
        tv[0]  = '{1'b0, 64'd0,         1'b1, B,             64'h1122334455667788, F,                     64'd0,                 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, B,             1'b0, 64'd0,         64'd0,                64'd0,                 64'h1122334455667788, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{1'b1, B,             1'b1, B,             64'h00AB000000000000, 64'h00FF000000000000, 64'h1122334455667788, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b1, B,             1'b0, 64'd0,         64'd0,                64'd0,                 64'h11AB334455667788, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{1'b1, B,             1'b1, B + 64'h28,    64'hDEAD,             F,                     64'h11AB334455667788, 1'b1, 1'b0, 1'b0};
        tv[5]  = '{1'b1, B + 64'h28,    1'b1, B + 64'h28,    64'hBEEF,             F,                     64'hDEAD,              1'b1, 1'b0, 1'b0};
        tv[6]  = '{1'b1, B + 64'h2D,    1'b0, 64'd0,         64'd0,                64'd0,                 64'hBEEF,              1'b1, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 64'h7FFFFFF8,  1'b1, B + 64'h78,    64'h0F0F,             F,                     64'd0,                 1'b1, 1'b1, 1'b0};
        tv[8]  = '{1'b1, B + 64'h80,    1'b1, 64'h7FFFFFF8,  F,                    F,                     64'd0,                 1'b1, 1'b1, 1'b0};
        tv[9]  = '{1'b1, B + 64'h78,    1'b0, 64'd0,         64'd0,                64'd0,                 64'h0F0F,              1'b1, 1'b0, 1'b1};
        tv[10] = '{1'b1, B + 64'h28,    1'b1, B + 64'h78,    F,                    64'd0,                 64'hBEEF,              1'b1, 1'b0, 1'b0};
        tv[11] = '{1'b1, B + 64'h78,    1'b0, 64'd0,         64'd0,                64'd0,                 64'h0F0F,              1'b1, 1'b0, 1'b0};
        tv[12] = '{1'b0, 64'd0,         1'b1, B + 64'h80,    F,                    F,                     64'd0,                 1'b0, 1'b0, 1'b0};
        tv[13] = '{1'b1, B,             1'b0, 64'd0,         64'd0,                64'd0,                 64'h11AB334455667788, 1'b1, 1'b0, 1'b1};

        clear_all();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state: latency-0 outputs forced low even with a read requested.
        if0.RamReadEnable = 1'b1;
        if0.RamReadAddr   = B;
        half();
        chk("rst_lat0_valid", 64'(if0.RamReadValid), 64'd0);
        chk("rst_lat0_err", 64'(if0.RamReadErr), 64'd0);
        chk("rst_lat0_data", if0.RamReadData, 64'd0);
        chk("rst_lat0_werr", 64'(if0.RamWriteErr), 64'd0);
        chk("rst_lat2_valid", 64'(if2.RamReadValid), 64'd0);
        chk("rst_lat3_data", if3.RamReadData, 64'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if0.RamReadEnable  = tv[i].re;
            if0.RamReadAddr    = tv[i].ra;
            if0.RamWriteEnable = tv[i].we;
            if0.RamWriteAddr   = tv[i].wa;
            if0.RamWriteData   = tv[i].wd;
            if0.RamWriteMask   = tv[i].wm;
            half();
            chk($sformatf("vec%0d_data", i), if0.RamReadData, tv[i].ed);
            chk($sformatf("vec%0d_valid", i), 64'(if0.RamReadValid), 64'(tv[i].ev));
            chk($sformatf("vec%0d_err", i), 64'(if0.RamReadErr), 64'(tv[i].ee));
            chk($sformatf("vec%0d_werr", i), 64'(if0.RamWriteErr), 64'(tv[i].ew));
            step();
        end

        // Writes are blocked during reset; outputs stay low.
        rst = 1'b1;
        if0.RamWriteEnable = 1'b1; if0.RamWriteAddr = B + 64'h28;
        if0.RamWriteData   = 64'h1234; if0.RamWriteMask = F;
        if0.RamReadEnable  = 1'b1; if0.RamReadAddr = B + 64'h28;
        half();
        chk("rstwr_lat0_valid", 64'(if0.RamReadValid), 64'd0);
        chk("rstwr_lat0_data", if0.RamReadData, 64'd0);
        step();
        rst = 1'b0;
        if0.RamReadEnable = 1'b1; if0.RamReadAddr = B + 64'h28;
        half();
        chk("rstwr_lat0_kept", if0.RamReadData, 64'hBEEF);
        step();

        // Latency 2: fill, back-to-back reads, RAW same cycle, in-flight write, out of range.
        drv(2, 1'b0, 64'd0, 1'b1, B,          64'hA0A0, F);
        drv(2, 1'b0, 64'd0, 1'b1, B + 64'h08, 64'hA1A1, F);
        drv(2, 1'b0, 64'd0, 1'b1, B + 64'h10, 64'hA2A2, F);
        drv(2, 1'b0, 64'd0, 1'b1, B + 64'h28, 64'hDEAD, F);
        drv(2, 1'b1, B,          1'b0, 64'd0, 64'd0, 64'd0);
        drv(2, 1'b1, B + 64'h08, 1'b0, 64'd0, 64'd0, 64'd0);
        drv(2, 1'b1, B + 64'h10, 1'b0, 64'd0, 64'd0, 64'd0);
        drv(2, 1'b1, B + 64'h28, 1'b1, B + 64'h28, 64'hBEEF, F);
        drv(2, 1'b1, B + 64'h28, 1'b0, 64'd0, 64'd0, 64'd0);
        drv(2, 1'b1, B + 64'h08, 1'b0, 64'd0, 64'd0, 64'd0);
        drv(2, 1'b0, 64'd0,      1'b1, B + 64'h08, 64'h5555, 64'h0000_0000_0000_FF00);
        drv(2, 1'b1, 64'h7FFFFFF8, 1'b0, 64'd0, 64'd0, 64'd0);
        drv(2, 1'b1, B + 64'h80,   1'b0, 64'd0, 64'd0, 64'd0);
        drv(2, 1'b1, B + 64'h08,   1'b0, 64'd0, 64'd0, 64'd0);
        drain();

        // Latency 3: fill and back-to-back reads.
        drv(3, 1'b0, 64'd0, 1'b1, B + 64'h18, 64'h3333, F);
        drv(3, 1'b0, 64'd0, 1'b1, B + 64'h20, 64'h4444, F);
        drv(3, 1'b1, B + 64'h18, 1'b0, 64'd0, 64'd0, 64'd0);
        drv(3, 1'b1, B + 64'h20, 1'b0, 64'd0, 64'd0, 64'd0);
        drain();

        // Latency 3: read then one-cycle reset; the read must vanish.
        if3.RamReadEnable = 1'b1;
        if3.RamReadAddr   = B + 64'h18;
        cyc_end();
        rst = 1'b1;
        half();
        chk("lat3_rst_valid", 64'(if3.RamReadValid), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            half();
            chk($sformatf("lat3_flush%0d_valid", i), 64'(if3.RamReadValid), 64'd0);
            chk($sformatf("lat3_flush%0d_data", i), if3.RamReadData, 64'd0);
            step();
        end
        drv(3, 1'b1, B + 64'h18, 1'b0, 64'd0, 64'd0, 64'd0);
        drv(3, 1'b1, B + 64'h20, 1'b0, 64'd0, 64'd0, 64'd0);
        drain();

        chk("lat2_queue_empty", 64'(q2.size()), 64'd0);
        chk("lat3_queue_empty", 64'(q3.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
